regfile_mp: RTL and testbench

//  Parametrised multi-port general-purpose register file; successor to the 2R/1W regfile.
//  N registered read ports, M write ports, same-cycle write->read bypass, register 0 hardwired to zero.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rd_port.sv | 77 +++++++
 rtl/regfile_mp.sv | 105 ++++++++++
 tb/tb_regfile_mp.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file.
//   RF_DATA_W / RF_ADDR_W : default register width and address width
//   RF_ZERO_WORD / RF_ZERO_ADDR : zero data word and the hardwired-zero register address
//   RF_RST_ACT : level of rst that holds the register file in reset
package regfile_pkg;
   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;

   localparam logic [RF_DATA_W-1:0] RF_ZERO_WORD = '0;
   localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = '0;

   localparam logic RF_RST_ACT = 1'b0;
endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port of regfile_mp.
// Selects, in priority order: disabled -> 0, address 0 -> 0, same-cycle write
// bypass (highest-index matching write port), stored register value.
// Optional macro REGFILE_SCOREBOARD_EN adds the registered busy flag for the port.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   i_re, i_raddr     read enable and address for this port
//   i_we, i_waddr,
//   i_wdata           all write ports, flattened (port k at k*W +: W)
//   i_reg_q           stored value of register i_raddr
//   i_busy_nxt        (macro) next-state busy bit of register i_raddr
//   o_busy            (macro) registered busy flag
//   o_rdata           registered read data
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_re,
   input  logic [ADDR_W-1:0]        i_raddr,
   input  logic [NUM_WR-1:0]        i_we,
   input  logic [NUM_WR*ADDR_W-1:0] i_waddr,
   input  logic [NUM_WR*DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0]        i_reg_q,
`ifdef REGFILE_SCOREBOARD_EN
   input  logic                     i_busy_nxt,
   output logic                     o_busy,
`endif
   output logic [DATA_W-1:0]        o_rdata
);

   logic [DATA_W-1:0] w_rdata_nxt;
   logic              w_addr_ok;

   assign w_addr_ok = i_re && (i_raddr != ADDR_W'(RF_ZERO_ADDR));

   // Ascending scan: a later (higher-index) matching write port overrides earlier ones.
   always_comb begin
      w_rdata_nxt = DATA_W'(RF_ZERO_WORD);
      if (w_addr_ok) begin
         w_rdata_nxt = i_reg_q;
         for (int k = 0; k < NUM_WR; k++) begin
            if (i_we[k] && (i_waddr[k*ADDR_W +: ADDR_W] == i_raddr))
               w_rdata_nxt = i_wdata[k*DATA_W +: DATA_W];
         end
      end
   end

   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RF_RST_ACT)
         r_rdata <= DATA_W'(RF_ZERO_WORD);
      else
         r_rdata <= w_rdata_nxt;
   end

   assign o_rdata = r_rdata;

`ifdef REGFILE_SCOREBOARD_EN
   logic r_busy;

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RF_RST_ACT)
         r_busy <= 1'b0;
      else
         r_busy <= w_addr_ok && i_busy_nxt;
   end

   assign o_busy = r_busy;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port general-purpose register file.
// NUM_RD registered read ports, NUM_WR write ports (higher index wins on the
// same address), same-cycle write->read bypass, register 0 reads as zero.
// Optional macro REGFILE_SCOREBOARD_EN adds a per-register busy scoreboard:
// sb_set marks a destination busy, any write clears it, set wins on a tie.
// Ports:
//   clk             clock
//   rst             asynchronous reset, active-low
//   we/waddr/wdata  write ports, flattened (port k at k*W +: W)
//   re/raddr        read ports, flattened (port j at j*ADDR_W +: ADDR_W)
//   rdata           registered read data, port j at j*DATA_W +: DATA_W
//   sb_set/sb_addr  (macro) mark sb_addr busy
//   rd_busy         (macro) registered busy flag per read port
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_RD = 3,
   parameter int NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] waddr,
   input  logic [NUM_WR*DATA_W-1:0] wdata,
   input  logic [NUM_RD-1:0]        re,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
`ifdef REGFILE_SCOREBOARD_EN
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_addr,
   output logic [NUM_RD-1:0]        rd_busy,
`endif
   output logic [NUM_RD*DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_regs [DEPTH];

   // Ascending loop: for several ports on one address the last assignment
   // (highest index) is the one that takes effect.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RF_RST_ACT) begin
         for (int a = 0; a < DEPTH; a++)
            r_regs[a] <= DATA_W'(RF_ZERO_WORD);
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (we[k] && (waddr[k*ADDR_W +: ADDR_W] != ADDR_W'(RF_ZERO_ADDR)))
               r_regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
         end
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_nxt;

   // Clears first, then the set, so an issue to a register being written
   // this cycle keeps it busy for the new producer.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int k = 0; k < NUM_WR; k++) begin
         if (we[k])
            w_busy_nxt[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (sb_set && (sb_addr != ADDR_W'(RF_ZERO_ADDR)))
         w_busy_nxt[sb_addr] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RF_RST_ACT)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end
`endif

   for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      logic [ADDR_W-1:0] w_raddr;
      assign w_raddr = raddr[j*ADDR_W +: ADDR_W];

      regfile_rd_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NUM_WR (NUM_WR)
      ) u_rd_port (
         .clk        (clk),
         .rst        (rst),
         .i_re       (re[j]),
         .i_raddr    (w_raddr),
         .i_we       (we),
         .i_waddr    (waddr),
         .i_wdata    (wdata),
         .i_reg_q    (r_regs[w_raddr]),
`ifdef REGFILE_SCOREBOARD_EN
         .i_busy_nxt (w_busy_nxt[w_raddr]),
         .o_busy     (rd_busy[j]),
`endif
         .o_rdata    (rdata[j*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters).
// Directed scenarios followed by randomized traffic against an array-based
// reference model. Scoreboard checks are active when REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;
   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NRD = 3;
   localparam int NWR = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NWR-1:0]    we;
   logic [NWR*AW-1:0] waddr;
   logic [NWR*DW-1:0] wdata;
   logic [NRD-1:0]    re;
   logic [NRD*AW-1:0] raddr;
   logic [NRD*DW-1:0] rdata;
`ifdef REGFILE_SCOREBOARD_EN
   logic              sb_set;
   logic [AW-1:0]     sb_addr;
   logic [NRD-1:0]    rd_busy;
`endif

   always #5 clk = ~clk;

   regfile_mp #(
      .DATA_W (DW),
      .ADDR_W (AW),
      .NUM_RD (NRD),
      .NUM_WR (NWR)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .re      (re),
      .raddr   (raddr),
`ifdef REGFILE_SCOREBOARD_EN
      .sb_set  (sb_set),
      .sb_addr (sb_addr),
      .rd_busy (rd_busy),
`endif
      .rdata   (rdata)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] m_regs [32];
   bit            m_busy [32];
   logic [DW-1:0] exp_rd [NRD];
   bit            exp_bz [NRD];

   task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
      end
   endtask

   task automatic clear_inputs();
      we = '0; waddr = '0; wdata = '0;
      re = '0; raddr = '0;
`ifdef REGFILE_SCOREBOARD_EN
      sb_set = 1'b0; sb_addr = '0;
`endif
   endtask

   task automatic set_wr(input int k, input bit en, input logic [AW-1:0] a, input logic [DW-1:0] d);
      we[k] = en;
      waddr[k*AW +: AW] = a;
      wdata[k*DW +: DW] = d;
   endtask

   task automatic set_rd(input int j, input bit en, input logic [AW-1:0] a);
      re[j] = en;
      raddr[j*AW +: AW] = a;
   endtask

   task automatic model_clear();
      for (int a = 0; a < 32; a++) begin
         m_regs[a] = '0;
         m_busy[a] = 1'b0;
      end
   endtask

   // One clock: predict from the current inputs and model, update the model,
   // then compare every read port after the edge.
   task automatic cycle(input string tag);
      for (int j = 0; j < NRD; j++) begin
         int a;
         a = int'(raddr[j*AW +: AW]);
         exp_rd[j] = '0;
         if (re[j] && a != 0) begin
            exp_rd[j] = m_regs[a];
            for (int k = 0; k < NWR; k++)
               if (we[k] && int'(waddr[k*AW +: AW]) == a)
                  exp_rd[j] = wdata[k*DW +: DW];
         end
      end
      for (int k = 0; k < NWR; k++) begin
         int a;
         a = int'(waddr[k*AW +: AW]);
         if (we[k] && a != 0) m_regs[a] = wdata[k*DW +: DW];
         if (we[k]) m_busy[a] = 1'b0;
      end
`ifdef REGFILE_SCOREBOARD_EN
      if (sb_set && sb_addr != 0) m_busy[int'(sb_addr)] = 1'b1;
`endif
      for (int j = 0; j < NRD; j++) begin
         int a;
         a = int'(raddr[j*AW +: AW]);
         exp_bz[j] = re[j] && (a != 0) && m_busy[a];
      end
      @(posedge clk);
      #1;
      for (int j = 0; j < NRD; j++) begin
         check_val($sformatf("%s_rd%0d", tag, j), rdata[j*DW +: DW], exp_rd[j]);
`ifdef REGFILE_SCOREBOARD_EN
         check_val($sformatf("%s_busy%0d", tag, j), 32'(rd_busy[j]), 32'(exp_bz[j]));
`endif
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int j = 0; j < NRD; j++) begin
         check_val($sformatf("%s_rd%0d", tag, j), rdata[j*DW +: DW], 32'h0);
`ifdef REGFILE_SCOREBOARD_EN
         check_val($sformatf("%s_busy%0d", tag, j), 32'(rd_busy[j]), 32'h0);
`endif
      end
   endtask

   // Assert reset away from a clock edge, check outputs clear at once,
   // hold across an edge, then release.
   task automatic mid_cycle_reset(input string tag);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero({tag, "_imm"});
      model_clear();
      @(posedge clk);
      #1;
      check_all_zero({tag, "_hold"});
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("rst_init");
      rst = 1'b1;

      // Reset: write reg5 (bypassed onto port 0), reset mid-cycle, read reg5 back.
      clear_inputs();
      set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
      set_rd(0, 1'b1, 5'd5);
      cycle("t1_wr");
      check_val("t1_pre_rst", rdata[0 +: DW], 32'hDEADBEEF);
      mid_cycle_reset("t1_rst");
      clear_inputs();
      set_rd(0, 1'b1, 5'd5);
      cycle("t1_after");
      check_val("t1_reg5", rdata[0 +: DW], 32'h0);

      // Zero register
      clear_inputs();
      set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
      set_rd(1, 1'b1, 5'd0);
      cycle("t2_wr");
      clear_inputs();
      set_rd(0, 1'b1, 5'd0);
      cycle("t2_rd");
      check_val("t2_zero", rdata[0 +: DW], 32'h0);

      // Bypass
      clear_inputs();
      set_wr(1, 1'b1, 5'd7, 32'h12345678);
      set_rd(2, 1'b1, 5'd7);
      cycle("t3_byp");
      check_val("t3_bypass", rdata[2*DW +: DW], 32'h12345678);
      clear_inputs();
      set_rd(0, 1'b1, 5'd7);
      cycle("t3_rd");
      check_val("t3_stored", rdata[0 +: DW], 32'h12345678);

      // Write conflict
      clear_inputs();
      set_wr(0, 1'b1, 5'd3, 32'hA);
      set_wr(1, 1'b1, 5'd3, 32'hB);
      set_rd(1, 1'b1, 5'd3);
      cycle("t4_cf");
      check_val("t4_bypass", rdata[1*DW +: DW], 32'hB);
      clear_inputs();
      set_rd(0, 1'b1, 5'd3);
      cycle("t4_rd");
      check_val("t4_stored", rdata[0 +: DW], 32'hB);

      // Disabled ports and all ports on one address
      clear_inputs();
      set_wr(0, 1'b1, 5'd9, 32'h55);
      cycle("t5_wr");
      clear_inputs();
      for (int j = 0; j < NRD; j++) set_rd(j, 1'b0, 5'd9);
      cycle("t5_dis");
      check_val("t5_disabled", rdata[2*DW +: DW], 32'h0);
      clear_inputs();
      for (int j = 0; j < NRD; j++) set_rd(j, 1'b1, 5'd9);
      cycle("t5_all");
      for (int j = 0; j < NRD; j++)
         check_val($sformatf("t5_port%0d", j), rdata[j*DW +: DW], 32'h55);

`ifdef REGFILE_SCOREBOARD_EN
      // Scoreboard: set, clear by write, set wins over a same-cycle write
      clear_inputs();
      sb_set = 1'b1; sb_addr = 5'd4;
      set_rd(0, 1'b1, 5'd4);
      cycle("t6_set");
      check_val("t6_busy_set", 32'(rd_busy[0]), 32'h1);
      clear_inputs();
      set_wr(0, 1'b1, 5'd4, 32'h44);
      set_rd(0, 1'b1, 5'd4);
      cycle("t6_clr");
      check_val("t6_busy_clr", 32'(rd_busy[0]), 32'h0);
      check_val("t6_data_clr", rdata[0 +: DW], 32'h44);
      clear_inputs();
      sb_set = 1'b1; sb_addr = 5'd4;
      set_wr(1, 1'b1, 5'd4, 32'h45);
      set_rd(0, 1'b1, 5'd4);
      cycle("t6_both");
      check_val("t6_busy_both", 32'(rd_busy[0]), 32'h1);
`endif

      // Randomized traffic, biased to a few low addresses to provoke
      // conflicts and bypasses; one reset in the middle.
      for (int i = 0; i < 400; i++) begin
         clear_inputs();
         for (int k = 0; k < NWR; k++)
            set_wr(k, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                   $urandom);
         for (int j = 0; j < NRD; j++)
            set_rd(j, $urandom_range(0, 3) != 0,
                   ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)));
`ifdef REGFILE_SCOREBOARD_EN
         sb_set  = 1'($urandom_range(0, 1));
         sb_addr = 5'($urandom_range(0, 7));
`endif
         cycle("rnd");
         if (i == 200) mid_cycle_reset("rnd_rst");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
